// File: rtl/mult_hilo_unit.sv
// -----------------------------------------------------------------------------
// mult_hilo_unit
//
// Multi-cycle multiply/accumulate unit for the EX stage. Owns the architectural
// HI/LO register pair and a separate MulOut register for the three-operand
// `mul` form. Multiplies run as a 32-iteration shift-add on operand
// magnitudes. The sign is applied once at the end, so signed and unsigned
// forms share one datapath.
//
// Ports:
//   Clk     in   1   rising-edge clock
//   Reset   in   1   asynchronous, active-low; clears all state
//   Start   in   1   EX-stage instruction valid this cycle
//   ALUOp   in   5   26 multu, 27 mflo, 28 mfhi, 29 msub, 30 madd, 31 mul
//   WrHi    in   1   mthi: write A to HI (idle only)
//   WrLo    in   1   mtlo: write A to LO (idle only)
//   A       in  32   rs operand
//   B       in  32   rt operand
//   Result  out 32   HI for mfhi, LO for mflo, otherwise MulOut
//   Busy    out  1   multiply in flight
//   Stall   out  1   hold IF/ID/EX
//   Done    out  1   one-cycle pulse after HI/LO/MulOut update
//   HI      out 32   current HI
//   LO      out 32   current LO
// -----------------------------------------------------------------------------
module mult_hilo_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [4:0]  ALUOp,
    input  logic        WrHi,
    input  logic        WrLo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Result,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [4:0] OP_MULTU = 5'd26;
    localparam logic [4:0] OP_MFLO  = 5'd27;
    localparam logic [4:0] OP_MFHI  = 5'd28;
    localparam logic [4:0] OP_MSUB  = 5'd29;
    localparam logic [4:0] OP_MADD  = 5'd30;
    localparam logic [4:0] OP_MUL   = 5'd31;

    logic [1:0]  state;
    logic [4:0]  op_q;
    logic        neg_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] prod_q;
    logic [5:0]  count_q;
    logic [31:0] mul_out_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        is_mul_op;
    logic        is_signed_op;
    logic        start_mul;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] q_val;
    logic [63:0] hilo;
    logic [63:0] hilo_add;
    logic [63:0] hilo_sub;

    // ------------------------------------------------------------------
    // Operation decode and operand conditioning
    // ------------------------------------------------------------------
    assign is_mul_op    = (ALUOp == OP_MULTU) || (ALUOp == OP_MSUB) ||
                          (ALUOp == OP_MADD)  || (ALUOp == OP_MUL);
    assign is_signed_op = (ALUOp == OP_MSUB) || (ALUOp == OP_MADD) ||
                          (ALUOp == OP_MUL);

    // A multiply is only accepted from IDLE; Start during Busy is dropped.
    assign start_mul = (state == ST_IDLE) && Start && is_mul_op;

    // Two's-complement magnitude. -2^31 maps to 0x80000000, which is the
    // correct unsigned magnitude, so no overflow handling is needed.
    assign abs_a = A[31] ? (~A + 32'd1) : A;
    assign abs_b = B[31] ? (~B + 32'd1) : B;

    // Final signed product and the two accumulate forms, all modulo 2^64.
    assign q_val    = neg_q ? (64'd0 - prod_q) : prod_q;
    assign hilo     = {hi_q, lo_q};
    assign hilo_add = hilo + q_val;
    assign hilo_sub = hilo - q_val;

    // ------------------------------------------------------------------
    // State, datapath and architectural registers
    // ------------------------------------------------------------------
    // NOTE: every register here is updated with non-blocking assignments so
    // that all right-hand sides see pre-edge values (e.g. prod_q uses the
    // old mcand_q while mcand_q shifts in the same edge).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            op_q      <= 5'd0;
            neg_q     <= 1'b0;
            mcand_q   <= 64'd0;
            mplier_q  <= 32'd0;
            prod_q    <= 64'd0;
            count_q   <= 6'd0;
            mul_out_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_mul) begin
                        op_q     <= ALUOp;
                        neg_q    <= is_signed_op ? (A[31] ^ B[31]) : 1'b0;
                        mcand_q  <= {32'd0, is_signed_op ? abs_a : A};
                        mplier_q <= is_signed_op ? abs_b : B;
                        prod_q   <= 64'd0;
                        count_q  <= 6'd0;
                        state    <= ST_MUL;
                    end else begin
                        // Moves are only honoured when no multiply starts.
                        if (WrHi) begin
                            hi_q <= A;
                        end
                        if (WrLo) begin
                            lo_q <= A;
                        end
                    end
                end

                ST_MUL: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    case (op_q)
                        OP_MULTU: {hi_q, lo_q} <= q_val;
                        OP_MADD:  {hi_q, lo_q} <= hilo_add;
                        OP_MSUB:  {hi_q, lo_q} <= hilo_sub;
                        default:  mul_out_q    <= q_val[31:0];
                    endcase
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // NOTE: Result gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        Result = mul_out_q;
        case (ALUOp)
            OP_MFHI: Result = hi_q;
            OP_MFLO: Result = lo_q;
            default: Result = mul_out_q;
        endcase
    end

    assign Busy  = (state != ST_IDLE);
    // Stall covers the Start cycle combinationally so IF/ID/EX freeze before
    // the unit has registered the operation.
    assign Stall = Busy || (Start && is_mul_op);
    assign Done  = done_q;
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_hilo_unit
//
// Self-checking bench for mult_hilo_unit. The reference model keeps HI, LO and
// MulOut as plain variables and computes each result with 64-bit arithmetic
// (sign-extended or zero-extended products, wrapping accumulate). Inputs are
// driven 1 time unit after the rising edge, and outputs are sampled at that
// same point.
// -----------------------------------------------------------------------------
module tb_mult_hilo_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  alu_op;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    // Reference model state
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic [31:0] mulout_m;

    mult_hilo_unit dut (
        .Clk    (clk),
        .Reset  (rst_n),
        .Start  (start),
        .ALUOp  (alu_op),
        .WrHi   (wr_hi),
        .WrLo   (wr_lo),
        .A      (a),
        .B      (b),
        .Result (result),
        .Busy   (busy),
        .Stall  (stall),
        .Done   (done),
        .HI     (hi),
        .LO     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent global time bound
    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // One multiply-family instruction, with Busy/Stall/Done window checks.
    // Called at a drive point (1 unit after an edge). It returns in the
    // Done cycle. If inject >= 0, a Start(multu)+WrHi+WrLo burst is
    // applied at that cycle offset and must be ignored.
    // ------------------------------------------------------------------
    task automatic run_mul(input logic [4:0] op, input logic [31:0] op_a,
                           input logic [31:0] op_b, input int inject);
        logic [63:0] p;
        bit          bad;
        int          bad_j;
        start  = 1'b1;
        alu_op = op;
        a      = op_a;
        b      = op_b;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_start op=%0d: got %b want 1", op, stall);
        end
        @(posedge clk); #1;
        start  = 1'b0;
        alu_op = 5'd0;
        bad    = 1'b0;
        bad_j  = -1;
        for (int j = 0; j <= 32; j++) begin
            if (!bad && (busy !== 1'b1 || stall !== 1'b1 || done !== 1'b0)) begin
                bad   = 1'b1;
                bad_j = j;
            end
            if (j == inject) begin
                start  = 1'b1;
                alu_op = 5'd26;
                wr_hi  = 1'b1;
                wr_lo  = 1'b1;
                a      = $urandom;
                b      = $urandom;
            end
            @(posedge clk); #1;
            start  = 1'b0;
            alu_op = 5'd0;
            wr_hi  = 1'b0;
            wr_lo  = 1'b0;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL busy_window op=%0d: first bad cycle N+%0d busy=%b stall=%b done=%b, want 1/1/0",
                     op, bad_j, busy, stall, done);
        end

        // Reference result
        if (op == 5'd26) p = {32'd0, op_a} * {32'd0, op_b};
        else             p = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        case (op)
            5'd26:   {hi_m, lo_m} = p;
            5'd30:   {hi_m, lo_m} = {hi_m, lo_m} + p;
            5'd29:   {hi_m, lo_m} = {hi_m, lo_m} - p;
            default: mulout_m = p[31:0];
        endcase

        vectors++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL fin_edge op=%0d: got busy=%b done=%b want busy=0 done=1", op, busy, done);
        end
        vectors++;
        if (hi !== hi_m || lo !== lo_m) begin
            miscompares++;
            $display("FAIL hilo op=%0d a=%h b=%h: got %h_%h want %h_%h", op, op_a, op_b, hi, lo, hi_m, lo_m);
        end
        vectors++;
        if (result !== mulout_m) begin
            miscompares++;
            $display("FAIL mulout op=%0d a=%h b=%h: got %h want %h", op, op_a, op_b, result, mulout_m);
        end
    endtask

    task automatic do_move(input bit w_hi, input bit w_lo, input logic [31:0] val);
        start = 1'b0;
        wr_hi = w_hi;
        wr_lo = w_lo;
        a     = val;
        @(posedge clk); #1;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        if (w_hi) hi_m = val;
        if (w_lo) lo_m = val;
        vectors++;
        if (hi !== hi_m || lo !== lo_m) begin
            miscompares++;
            $display("FAIL move hi=%b lo=%b: got %h_%h want %h_%h", w_hi, w_lo, hi, lo, hi_m, lo_m);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        alu_op = 5'd0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        a      = 32'd0;
        b      = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0; mulout_m = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0 || result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got hi=%h lo=%h result=%h want 0", hi, lo, result);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got busy=%b done=%b stall=%b want 0", busy, done, stall);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu_max;
        run_mul(5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        vectors++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL multu_max: got %h_%h want fffffffe_00000001", hi, lo);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_single: got %b want 0", done);
        end
    endtask

    task automatic test_mul;
        do_move(1'b1, 1'b1, 32'h1111_1111);
        do_move(1'b0, 1'b1, 32'h2222_2222);
        run_mul(5'd31, 32'hFFFF_FFFD, 32'd7, -1);
        vectors++;
        if (result !== 32'hFFFF_FFEB || hi !== 32'h1111_1111 || lo !== 32'h2222_2222) begin
            miscompares++;
            $display("FAIL mul_neg: got result=%h hi=%h lo=%h want ffffffeb 11111111 22222222",
                     result, hi, lo);
        end
    endtask

    task automatic test_accumulate;
        do_move(1'b1, 1'b0, 32'h0000_0000);
        do_move(1'b0, 1'b1, 32'hFFFF_FFFF);
        run_mul(5'd30, 32'd1, 32'd1, -1);
        vectors++;
        if (hi !== 32'h0000_0001 || lo !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL madd_carry: got %h_%h want 00000001_00000000", hi, lo);
        end
        do_move(1'b1, 1'b1, 32'h0000_0000);
        run_mul(5'd29, 32'd2, 32'd3, -1);
        vectors++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            miscompares++;
            $display("FAIL msub_borrow: got %h_%h want ffffffff_fffffffa", hi, lo);
        end
        run_mul(5'd31, 32'h8000_0000, 32'h8000_0000, -1);
        vectors++;
        if (result !== 32'd0) begin
            miscompares++;
            $display("FAIL mul_extreme: got %h want 00000000", result);
        end
        do_move(1'b1, 1'b1, 32'h0000_0000);
        run_mul(5'd30, 32'h8000_0000, 32'h8000_0000, -1);
        vectors++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL madd_extreme: got %h_%h want 40000000_00000000", hi, lo);
        end
    endtask

    task automatic test_moves;
        do_move(1'b1, 1'b0, 32'hDEAD_BEEF);
        alu_op = 5'd27;
        #1;
        vectors++;
        if (result !== lo_m) begin
            miscompares++;
            $display("FAIL mflo: got %h want %h", result, lo_m);
        end
        alu_op = 5'd28;
        #1;
        vectors++;
        if (result !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL mfhi: got %h want deadbeef", result);
        end
        alu_op = 5'd0;
        // Non-multiply Start is ignored and does not stall
        start  = 1'b1;
        alu_op = 5'd5;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_nonmul: got %b want 0", stall);
        end
        @(posedge clk); #1;
        start  = 1'b0;
        alu_op = 5'd0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_nonmul: got %b want 0", busy);
        end
    endtask

    task automatic test_ignored;
        do_move(1'b1, 1'b1, 32'h0BAD_F00D);
        run_mul(5'd26, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_start: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        run_mul(5'd26, 32'd100, 32'd200, -1);
        run_mul(5'd30, 32'hFFFF_FFFF, 32'd5, -1);
        run_mul(5'd31, 32'd12345, 32'hFFFF_0000, -1);
    endtask

    task automatic test_random;
        logic [4:0] ops [4];
        logic [31:0] ra;
        logic [31:0] rb;
        ops[0] = 5'd26; ops[1] = 5'd29; ops[2] = 5'd30; ops[3] = 5'd31;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(3) == 0)
                do_move($urandom_range(1) == 1, $urandom_range(1) == 1, $urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7) == 0) ra = 32'h8000_0000;
            if ($urandom_range(7) == 0) rb = 32'hFFFF_FFFF;
            run_mul(ops[$urandom_range(3)], ra, rb, -1);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        do_move(1'b1, 1'b1, 32'h5555_AAAA);
        start  = 1'b1;
        alu_op = 5'd30;
        a      = 32'd77;
        b      = 32'd99;
        @(posedge clk); #1;
        start  = 1'b0;
        alu_op = 5'd0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        hi_m = 32'd0; lo_m = 32'd0; mulout_m = 32'd0;
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_hilo: got %h_%h want 0", hi, lo);
        end
        vectors++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_flags: got busy=%b stall=%b done=%b want 0", busy, stall, done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL reset_mid_ghost: got stray done/busy after reset, want none");
        end
        run_mul(5'd26, 32'd6, 32'd7, -1);
        vectors++;
        if (lo !== 32'd42 || hi !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_fresh: got %h_%h want 00000000_0000002a", hi, lo);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_multu_max();
        test_mul();
        test_accumulate();
        test_moves();
        test_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
